// File: rtl/hazard_pkg.sv
// Shared opcode table and instruction classification for the ID-stage hazard unit.
package hazard_pkg;

    localparam int SHD_RD_W = 5;

    localparam logic [6:0] OPC_NOP    = 7'b0000000;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AMO    = 7'b0101111;

    typedef struct packed {
        logic [SHD_RD_W-1:0] rd;
        logic                wr;
        logic                ld;
    } shadow_t;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL || opc == OPC_NOP);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_OP || opc == OPC_STORE || opc == OPC_BRANCH || opc == OPC_AMO);
    endfunction

    function automatic logic writes_rd(input logic [6:0] opc);
        return (opc == OPC_LUI  || opc == OPC_AUIPC  || opc == OPC_JAL || opc == OPC_JALR ||
                opc == OPC_LOAD || opc == OPC_OP_IMM || opc == OPC_OP  || opc == OPC_AMO);
    endfunction

endpackage

// File: rtl/hazard_detection_unit_shadow.sv
// One shadow pipeline slot (EX or MEM): holds {rd, writes-rd, is-load} with freeze and bubble.
module hazard_shadow_stage #(
    parameter int REG_W = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             hold_i,
    input  logic             bubble_i,
    input  logic [REG_W-1:0] rd_i,
    input  logic             wr_i,
    input  logic             ld_i,
    output logic [REG_W-1:0] rd_o,
    output logic             wr_o,
    output logic             ld_o
);

    logic [REG_W-1:0] rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             ld_q, ld_d;

    always_comb begin
        rd_d = rd_i;
        wr_d = wr_i;
        ld_d = ld_i;
        if (bubble_i) begin
            rd_d = '0;
            wr_d = 1'b0;
            ld_d = 1'b0;
        end
    end

    // Reset clears the slot even while the pipeline is frozen.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_q <= '0;
            wr_q <= 1'b0;
            ld_q <= 1'b0;
        end else if (!hold_i) begin
            rd_q <= rd_d;
            wr_q <= wr_d;
            ld_q <= ld_d;
        end
    end

    assign rd_o = rd_q;
    assign wr_o = wr_q;
    assign ld_o = ld_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use and branch-operand hazard detection beside ID; produces stall and bubble controls
// from the ID fields and private shadow copies of the EX and MEM destinations.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int REG_W     = 5,
    parameter int OPC_W     = 7,
    parameter bit X0_HAZARD = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPC_W-1:0] opcode,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic [REG_W-1:0] rd_id,
    input  logic             flush_id,
    input  logic             hold,
    output logic             stall,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_bubble,
    output logic [REG_W-1:0] rd_ex_s,
    output logic [REG_W-1:0] rd_mem_s
);

    logic [REG_W-1:0] ex_rd, mem_rd;
    logic             ex_wr, ex_ld, mem_wr, mem_ld;
    logic             use1, use2, is_branch, wr_id, ld_id;
    logic             match_ex, match_mem;
    logic             hz_load_use, hz_br_alu, hz_br_load;

    function automatic logic reg_match(input logic             use_r,
                                       input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] dst);
        return use_r && (src == dst) && (X0_HAZARD || (dst != '0));
    endfunction

    assign use1      = uses_rs1(opcode);
    assign use2      = uses_rs2(opcode);
    assign wr_id     = writes_rd(opcode);
    assign ld_id     = (opcode == OPC_LOAD);
    assign is_branch = (opcode == OPC_BRANCH);

    assign match_ex  = reg_match(use1, rs1_id, ex_rd)  | reg_match(use2, rs2_id, ex_rd);
    assign match_mem = reg_match(use1, rs1_id, mem_rd) | reg_match(use2, rs2_id, mem_rd);

    // Branches resolve in ID, so they also wait on an ALU result in EX and on load data in MEM.
    assign hz_load_use = ex_ld & match_ex;
    assign hz_br_alu   = is_branch & ex_wr & !ex_ld & match_ex;
    assign hz_br_load  = is_branch & mem_wr & mem_ld & match_mem;

    assign stall        = !flush_id & !reset & (hz_load_use | hz_br_alu | hz_br_load);
    assign pc_en        = !(stall | hold);
    assign if_id_en     = !(stall | hold);
    assign id_ex_bubble = stall & !hold;

    hazard_shadow_stage #(.REG_W(REG_W)) u_ex_shadow (
        .clk_i    (clk),
        .reset_i  (reset),
        .hold_i   (hold),
        .bubble_i (stall | flush_id),
        .rd_i     (rd_id),
        .wr_i     (wr_id),
        .ld_i     (ld_id),
        .rd_o     (ex_rd),
        .wr_o     (ex_wr),
        .ld_o     (ex_ld)
    );

    hazard_shadow_stage #(.REG_W(REG_W)) u_mem_shadow (
        .clk_i    (clk),
        .reset_i  (reset),
        .hold_i   (hold),
        .bubble_i (1'b0),
        .rd_i     (ex_rd),
        .wr_i     (ex_wr),
        .ld_i     (ex_ld),
        .rd_o     (mem_rd),
        .wr_o     (mem_wr),
        .ld_o     (mem_ld)
    );

    assign rd_ex_s  = ex_rd;
    assign rd_mem_s = mem_rd;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit: directed hazard sequences plus random traffic.
module tb_hazard_detection_unit;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OPIMM  = 7'b0010011;
    localparam logic [6:0] AMO    = 7'b0101111;
    localparam logic [6:0] SYS    = 7'b1110011;
    localparam logic [6:0] NOP    = 7'b0000000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = '0;
    logic [4:0] rs1_id = '0, rs2_id = '0, rd_id = '0;
    logic       flush_id = 1'b0, hold = 1'b0;
    logic       stall, pc_en, if_id_en, id_ex_bubble;
    logic [4:0] rd_ex_s, rd_mem_s;

    hazard_detection_unit dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .rs1_id       (rs1_id),
        .rs2_id       (rs2_id),
        .rd_id        (rd_id),
        .flush_id     (flush_id),
        .hold         (hold),
        .stall        (stall),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_bubble (id_ex_bubble),
        .rd_ex_s      (rd_ex_s),
        .rd_mem_s     (rd_mem_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       stall;
        bit       pc_en;
        bit       if_id_en;
        bit       bubble;
        bit       chk_rd;
        bit [4:0] rd_ex;
        bit [4:0] rd_mem;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the instructions currently in flight in EX and MEM (opcode 0 = bubble).
    logic [6:0] ex_op = '0, mem_op = '0;
    logic [4:0] ex_rd = '0, mem_rd = '0;
    bit         known = 1'b0;

    function automatic bit reads1(input logic [6:0] op);
        return !(op inside {LUI, AUIPC, JAL, NOP});
    endfunction

    function automatic bit reads2(input logic [6:0] op);
        return op inside {OP, STORE, BRANCH, AMO};
    endfunction

    function automatic bit writes(input logic [6:0] op);
        return op inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, AMO};
    endfunction

    function automatic bit model_stall(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                                       input bit fl, input bit rs);
        logic [4:0] srcs[$];
        bit s = 1'b0;
        if (fl || rs) return 1'b0;
        if (reads1(op)) srcs.push_back(r1);
        if (reads2(op)) srcs.push_back(r2);
        foreach (srcs[i]) begin
            if (writes(ex_op) && ex_rd == srcs[i] && (ex_op == LOAD || op == BRANCH)) s = 1'b1;
            if (op == BRANCH && mem_op == LOAD && mem_rd == srcs[i]) s = 1'b1;
        end
        return s;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input bit fl, input bit hd, input bit rs);
        exp_t e;
        bit   s;
        opcode   = op;
        rs1_id   = r1;
        rs2_id   = r2;
        rd_id    = rd;
        flush_id = fl;
        hold     = hd;
        reset    = rs;
        s          = model_stall(op, r1, r2, fl, rs);
        e.stall    = s;
        e.pc_en    = !(s || hd);
        e.if_id_en = !(s || hd);
        e.bubble   = s && !hd;
        e.chk_rd   = known;
        e.rd_ex    = ex_rd;
        e.rd_mem   = mem_rd;
        sbq.push_back(e);
        @(posedge clk);
        if (rs) begin
            ex_op = NOP; ex_rd = '0; mem_op = NOP; mem_rd = '0;
            known = 1'b1;
        end else if (!hd) begin
            mem_op = ex_op;
            mem_rd = ex_rd;
            if (s || fl) begin
                ex_op = NOP; ex_rd = '0;
            end else begin
                ex_op = op; ex_rd = rd;
            end
        end
        #1;
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("stall", int'(stall), int'(e.stall));
                chk("pc_en", int'(pc_en), int'(e.pc_en));
                chk("if_id_en", int'(if_id_en), int'(e.if_id_en));
                chk("id_ex_bubble", int'(id_ex_bubble), int'(e.bubble));
                if (e.chk_rd) begin
                    chk("rd_ex_s", int'(rd_ex_s), int'(e.rd_ex));
                    chk("rd_mem_s", int'(rd_mem_s), int'(e.rd_mem));
                end
            end
        end
    end

    logic [6:0] optab [12];

    initial begin
        optab = '{LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, OP, OPIMM, AMO, SYS, NOP};
        @(posedge clk);
        #1;
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step(NOP, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        nops(1);

        // load-use, non-branch consumer
        step(LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        step(OP,   5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0);
        step(OP,   5'd5, 5'd1, 5'd6, 1'b0, 1'b0, 1'b0);
        nops(2);
        // load then dependent branch
        step(LOAD,   5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        repeat (3) step(BRANCH, 5'd5, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        nops(2);
        // ALU result feeding a branch, and feeding an ALU op
        step(OPIMM,  5'd1, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0);
        repeat (2) step(BRANCH, 5'd3, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
        nops(2);
        step(OPIMM, 5'd1, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0);
        step(OPIMM, 5'd7, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0);
        nops(2);
        // consumers that must not stall
        step(LOAD,  5'd1, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        step(OPIMM, 5'd1, 5'd4, 5'd9, 1'b0, 1'b0, 1'b0);
        nops(2);
        step(LOAD, 5'd1, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        step(JAL,  5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0);
        nops(2);
        step(LOAD, 5'd1, 5'd0, 5'd4, 1'b0, 1'b0, 1'b0);
        step(LUI,  5'd4, 5'd4, 5'd4, 1'b0, 1'b0, 1'b0);
        nops(2);
        // hold during the first stall of a load/branch pair
        step(LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        repeat (3) step(BRANCH, 5'd5, 5'd2, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) step(BRANCH, 5'd5, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        nops(2);
        // reset in the first stall cycle
        step(LOAD,   5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        step(BRANCH, 5'd5, 5'd2, 5'd0, 1'b0, 1'b0, 1'b1);
        step(BRANCH, 5'd5, 5'd2, 5'd0, 1'b0, 1'b0, 1'b0);
        nops(2);
        // flush wins over a load-use hazard
        step(LOAD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0, 1'b0);
        step(OP,   5'd5, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0);
        nops(2);

        for (int i = 0; i < 3000; i++) begin
            step(optab[$urandom_range(0, 11)],
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0), ($urandom_range(0, 49) == 0));
        end

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
